// File: rtl/dm_csr_initiator_if.sv
// Host-side request/completion channel and DMI request/response channel of
// the DM CSR initiator, bundled in one interface. Signal names are given from
// the initiator's point of view (_i = into the initiator, _o = out of it).
interface dm_csr_initiator_if;
  // Host request / completion
  logic        host_valid_i;
  logic        host_ready_o;
  logic        host_write_i;
  logic [6:0]  host_addr_i;
  logic [31:0] host_wdata_i;
  logic        done_valid_o;
  logic [31:0] done_rdata_o;
  logic        done_err_o;

  // DMI request / response
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i;
  logic [1:0]  dmi_resp_resp_i;

  // The initiator itself
  modport master (
    input  host_valid_i, host_write_i, host_addr_i, host_wdata_i,
    output host_ready_o, done_valid_o, done_rdata_o, done_err_o,
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    input  dmi_req_ready_i,
    input  dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    output dmi_resp_ready_o
  );

  // The environment: host plus DMI target
  modport slave (
    output host_valid_i, host_write_i, host_addr_i, host_wdata_i,
    input  host_ready_o, done_valid_o, done_rdata_o, done_err_o,
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    output dmi_req_ready_i,
    output dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    input  dmi_resp_ready_o
  );
endinterface

// File: rtl/dm_csr_initiator.sv
// DM CSR initiator: turns single host CSR accesses into DMI transactions.
// A write to the Command register is followed by AbstractCS polling until the
// abstract command is no longer busy, an error is reported, or the poll budget
// runs out. Every accepted request ends with a one-cycle completion pulse.
module dm_csr_initiator #(
  parameter int unsigned POLL_LIMIT = 16,
  parameter int unsigned BUSY_BIT   = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dm_csr_initiator_if.master bus
);

  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  localparam logic [6:0] ADDR_LO         = 7'h04;
  localparam logic [6:0] ADDR_HI         = 7'h17;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_POLL_REQ,
    S_POLL_RESP,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               write_q;
  logic [6:0]         addr_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   poll_cnt_q;
  logic [31:0]        done_rdata_q;
  logic               done_err_q;

  logic               host_accept;
  logic               req_fire;
  logic               resp_fire;
  logic               resp_busy;
  logic               resp_cmderr;
  logic [CNT_W-1:0]   poll_cnt_inc;
  logic               poll_last;

  logic               done_load;
  logic [31:0]        done_rdata_d;
  logic               done_err_d;
  logic               poll_clr;
  logic               poll_step;

  // Handshakes and decoded response fields
  assign host_accept  = bus.host_valid_i & bus.host_ready_o;
  assign req_fire     = bus.dmi_req_valid_o & bus.dmi_req_ready_i;
  assign resp_fire    = bus.dmi_resp_valid_i & bus.dmi_resp_ready_o;
  assign resp_busy    = bus.dmi_resp_data_i[BUSY_BIT];
  assign resp_cmderr  = |bus.dmi_resp_data_i[10:8];
  assign poll_cnt_inc = (poll_cnt_q == CNT_W'(POLL_LIMIT)) ? poll_cnt_q
                                                           : poll_cnt_q + 1'b1;
  assign poll_last    = (poll_cnt_inc == CNT_W'(POLL_LIMIT));

  // Host side: ready is withheld while reset is asserted so it first rises
  // after release; completion data is held between completions.
  assign bus.host_ready_o = (state_q == S_IDLE) & rst_ni;
  assign bus.done_valid_o = (state_q == S_DONE);
  assign bus.done_rdata_o = done_rdata_q;
  assign bus.done_err_o   = done_err_q;

  // DMI side: request fields come straight from captured registers, so they
  // cannot change while a request waits for ready.
  assign bus.dmi_req_valid_o  = (state_q == S_REQ) | (state_q == S_POLL_REQ);
  assign bus.dmi_resp_ready_o = (state_q == S_RESP) | (state_q == S_POLL_RESP);
  assign bus.dmi_req_op_o     = (state_q == S_REQ)      ? (write_q ? OP_WRITE : OP_READ) :
                                (state_q == S_POLL_REQ) ? OP_READ : OP_NOP;
  assign bus.dmi_req_addr_o   = (state_q == S_REQ)      ? addr_q          :
                                (state_q == S_POLL_REQ) ? ADDR_ABSTRACTCS : '0;
  assign bus.dmi_req_data_o   = ((state_q == S_REQ) && write_q) ? wdata_q : '0;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode plus completion and poll-counter controls
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // forgets one would otherwise infer a latch.
    state_d      = state_q;
    done_load    = 1'b0;
    done_rdata_d = '0;
    done_err_d   = 1'b0;
    poll_clr     = 1'b0;
    poll_step    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (host_accept) begin
          if ((bus.host_addr_i >= ADDR_LO) && (bus.host_addr_i <= ADDR_HI)) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_DONE;
            done_load  = 1'b1;
            done_err_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (req_fire) state_d = S_RESP;
      end

      S_RESP: begin
        if (resp_fire) begin
          if (bus.dmi_resp_resp_i != 2'd0) begin
            state_d    = S_DONE;
            done_load  = 1'b1;
            done_err_d = 1'b1;
          end else if (!write_q) begin
            state_d      = S_DONE;
            done_load    = 1'b1;
            done_rdata_d = bus.dmi_resp_data_i;
          end else if (addr_q != ADDR_COMMAND) begin
            state_d   = S_DONE;
            done_load = 1'b1;
          end else begin
            state_d  = S_POLL_REQ;
            poll_clr = 1'b1;
          end
        end
      end

      S_POLL_REQ: begin
        if (req_fire) state_d = S_POLL_RESP;
      end

      S_POLL_RESP: begin
        if (resp_fire) begin
          poll_step = 1'b1;
          if (bus.dmi_resp_resp_i != 2'd0) begin
            state_d    = S_DONE;
            done_load  = 1'b1;
            done_err_d = 1'b1;
          end else if (!resp_busy) begin
            state_d      = S_DONE;
            done_load    = 1'b1;
            done_rdata_d = bus.dmi_resp_data_i;
            done_err_d   = resp_cmderr;
          end else if (poll_last) begin
            state_d      = S_DONE;
            done_load    = 1'b1;
            done_rdata_d = bus.dmi_resp_data_i;
            done_err_d   = 1'b1;
          end else begin
            state_d = S_POLL_REQ;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Captured request fields, poll counter and held completion result
  always_ff @(posedge clk_i) begin
    // NOTE: these registers are reset too, because the completion fields are
    // visible outputs that must read zero out of reset.
    if (!rst_ni) begin
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      poll_cnt_q   <= '0;
      done_rdata_q <= '0;
      done_err_q   <= 1'b0;
    end else begin
      if (host_accept) begin
        write_q <= bus.host_write_i;
        addr_q  <= bus.host_addr_i;
        wdata_q <= bus.host_wdata_i;
      end
      if (poll_clr)       poll_cnt_q <= '0;
      else if (poll_step) poll_cnt_q <= poll_cnt_inc;
      if (done_load) begin
        done_rdata_q <= done_rdata_d;
        done_err_q   <= done_err_d;
      end
    end
  end

endmodule

// File: tb/tb_dm_csr_initiator.sv
// Self-checking bench for dm_csr_initiator: directed scenarios plus randomized
// traffic, a DMI target model, and a scoreboard checked by a done monitor.
module tb_dm_csr_initiator;

  localparam int POLL_LIMIT = 16;
  localparam int BUSY_BIT   = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_csr_initiator_if bus ();

  dm_csr_initiator #(
    .POLL_LIMIT (POLL_LIMIT),
    .BUSY_BIT   (BUSY_BIT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  // One expected DMI request and the response the target will return
  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
    bit          chk_data;
    logic [31:0] rsp_data;
    logic [1:0]  rsp;
    int          req_delay;
    int          rsp_delay;
    bit          junk;
  } dmi_t;

  // Expected completion of one host request
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
    int          n_dmi;
    int          lat;
  } exp_t;

  dmi_t        plan_q[$];
  exp_t        sb_q[$];
  int          acc_q[$];
  logic [31:0] pd_q[$];
  logic [1:0]  pr_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int dmi_total = 0;
  int poll_hs = 0;
  bit zero_wait = 1'b0;
  int force_req_delay = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic dmi_t mk_dmi(input logic [6:0] addr, input logic [1:0] op,
                                  input logic [31:0] data, input bit chk,
                                  input logic [31:0] rdata, input logic [1:0] rsp);
    dmi_t d;
    d.addr = addr; d.op = op; d.data = data; d.chk_data = chk;
    d.rsp_data = rdata; d.rsp = rsp;
    d.req_delay = zero_wait ? 0 : int'($urandom_range(0, 3));
    d.rsp_delay = zero_wait ? 0 : int'($urandom_range(0, 3));
    d.junk      = zero_wait ? 1'b0 : ($urandom_range(0, 3) == 0);
    if (force_req_delay >= 0) d.req_delay = force_req_delay;
    return d;
  endfunction

  task automatic wait_drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    check("done_timeout", 32'(sb_q.size()), 0);
    check("dmi_plan_drained", 32'(plan_q.size()), 0);
    sb_q.delete(); acc_q.delete(); plan_q.delete();
  endtask

  task automatic drive_host(input logic [6:0] addr, input bit write,
                            input logic [31:0] wdata, input bit expect_done);
    int g = 0;
    bus.host_addr_i  = addr;
    bus.host_write_i = write;
    bus.host_wdata_i = wdata;
    bus.host_valid_i = 1'b1;
    while (bus.host_ready_o !== 1'b1 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("host_accept_timeout", 32'(g >= 200), 0);
    if (expect_done) acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    bus.host_valid_i = 1'b0;
    bus.host_addr_i  = 7'($urandom);
    bus.host_wdata_i = $urandom;
  endtask

  // Reference model: walks the CSR access rules and the AbstractCS poll list
  // to produce the DMI traffic plan and the expected completion.
  task automatic run_txn(input logic [6:0] addr, input bit write,
                         input logic [31:0] wdata, input logic [1:0] mresp,
                         input logic [31:0] mdata, input bit expect_done);
    exp_t e;
    e.rdata = '0; e.err = 1'b0; e.chk_rdata = 1'b1; e.n_dmi = 0; e.lat = -1;
    if (addr < 7'h04 || addr > 7'h17) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      plan_q.push_back(mk_dmi(addr, write ? 2'd2 : 2'd1, wdata, write, mdata, mresp));
      e.n_dmi = 1;
      if (mresp != 2'd0) begin
        e.err = 1'b1; e.chk_rdata = 1'b0;
      end else if (!write) begin
        e.rdata = mdata;
      end else if (addr == 7'h17) begin
        for (int i = 0; i < POLL_LIMIT; i++) begin
          logic [31:0] d;
          logic [1:0]  r;
          d = (i < pd_q.size()) ? pd_q[i] : (32'h1 << BUSY_BIT);
          r = (i < pr_q.size()) ? pr_q[i] : 2'd0;
          plan_q.push_back(mk_dmi(7'h16, 2'd1, '0, 1'b0, d, r));
          e.n_dmi++;
          if (r != 2'd0) begin e.err = 1'b1; e.chk_rdata = 1'b0; break; end
          if (!d[BUSY_BIT]) begin e.rdata = d; e.err = (d[10:8] != 3'd0); break; end
          if (i + 1 == POLL_LIMIT) begin e.err = 1'b1; e.rdata = d; end
        end
      end
      if (zero_wait) e.lat = 1 + 2 * e.n_dmi;
    end
    if (expect_done) sb_q.push_back(e);
    drive_host(addr, write, wdata, expect_done);
    if (expect_done) wait_drain();
  endtask

  // DMI target: follows the plan, checks request fields every cycle they are
  // presented, and answers with the planned response after planned delays.
  initial begin : responder
    dmi_t cur;
    bit   have_cur;
    int   phase;
    int   cnt;
    bit   hs_seen;
    have_cur = 1'b0; phase = 0; cnt = 0; hs_seen = 1'b0;
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_valid_i = 1'b0;
    bus.dmi_resp_data_i  = '0;
    bus.dmi_resp_resp_i  = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        plan_q.delete();
        have_cur = 1'b0; phase = 0;
        bus.dmi_req_ready_i  = 1'b0;
        bus.dmi_resp_valid_i = 1'b0;
      end else begin
        if (phase == 2 && hs_seen) begin
          bus.dmi_resp_valid_i = 1'b0;
          phase = 0;
        end
        if (phase == 1) begin
          bus.dmi_req_ready_i  = 1'b0;
          bus.dmi_resp_valid_i = 1'b0;
          dmi_total++;
          if (cur.addr == 7'h16) poll_hs++;
          have_cur = 1'b0;
          if (cur.rsp_delay == 0) begin
            bus.dmi_resp_valid_i = 1'b1;
            bus.dmi_resp_data_i  = cur.rsp_data;
            bus.dmi_resp_resp_i  = cur.rsp;
            phase = 2;
          end else begin
            cnt = 0; phase = 3;
          end
        end else if (phase == 3) begin
          cnt++;
          if (cnt >= cur.rsp_delay) begin
            bus.dmi_resp_valid_i = 1'b1;
            bus.dmi_resp_data_i  = cur.rsp_data;
            bus.dmi_resp_resp_i  = cur.rsp;
            phase = 2;
          end
        end else if (phase == 0) begin
          bus.dmi_resp_valid_i = 1'b0;
          if (bus.dmi_req_valid_o === 1'b1) begin
            if (!have_cur) begin
              if (plan_q.size() == 0) begin
                check("unexpected_dmi_req", 1, 0);
                cur = mk_dmi(bus.dmi_req_addr_o, bus.dmi_req_op_o, '0, 1'b0, '0, 2'd0);
              end else begin
                cur = plan_q.pop_front();
              end
              have_cur = 1'b1; cnt = 0;
            end
            check("dmi_req_addr", 32'(bus.dmi_req_addr_o), 32'(cur.addr));
            check("dmi_req_op", 32'(bus.dmi_req_op_o), 32'(cur.op));
            if (cur.chk_data) check("dmi_req_data", bus.dmi_req_data_o, cur.data);
            if (cnt >= cur.req_delay) begin
              bus.dmi_req_ready_i = 1'b1;
              phase = 1;
              if (cur.junk) begin
                bus.dmi_resp_valid_i = 1'b1;
                bus.dmi_resp_data_i  = 32'hBADC0FFE;
                bus.dmi_resp_resp_i  = 2'd2;
              end
            end else begin
              cnt++;
            end
          end
        end
        if (phase == 2) hs_seen = bus.dmi_resp_ready_o;
      end
    end
  end

  // Done monitor: pops the scoreboard on every completion pulse
  initial begin : monitor
    exp_t e;
    int   a;
    int   last;
    last = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        last = dmi_total;
      end else if (bus.done_valid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -1;
          check("done_err", 32'(bus.done_err_o), 32'(e.err));
          if (e.chk_rdata) check("done_rdata", bus.done_rdata_o, e.rdata);
          check("dmi_req_count", 32'(dmi_total - last), 32'(e.n_dmi));
          if (e.lat > 0 && a >= 0) check("done_latency", 32'(cyc - a + 1), 32'(e.lat));
        end
        last = dmi_total;
      end
    end
  end

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin : stimulus
    logic [6:0]  addr;
    logic        wr;
    logic [1:0]  mresp;
    int          k;
    int          g;
    bus.host_valid_i = 1'b0;
    bus.host_write_i = 1'b0;
    bus.host_addr_i  = '0;
    bus.host_wdata_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_host_ready", 32'(bus.host_ready_o), 0);
    check("rst_done_valid", 32'(bus.done_valid_o), 0);
    check("rst_done_err", 32'(bus.done_err_o), 0);
    check("rst_done_rdata", bus.done_rdata_o, 0);
    check("rst_dmi_req_valid", 32'(bus.dmi_req_valid_o), 0);
    check("rst_dmi_req_op", 32'(bus.dmi_req_op_o), 0);
    check("rst_dmi_resp_ready", 32'(bus.dmi_resp_ready_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_host_ready", 32'(bus.host_ready_o), 1);

    // Directed, zero-wait target
    zero_wait = 1'b1;
    pd_q.delete(); pr_q.delete();
    run_txn(7'h04, 1'b0, '0, 2'd0, 32'hDEADBEEF, 1'b1);
    pd_q = '{32'h1000, 32'h1000, 32'h0000};
    run_txn(7'h17, 1'b1, 32'h00220000, 2'd0, 32'h0, 1'b1);
    pd_q = '{32'h0300};
    run_txn(7'h17, 1'b1, 32'h00220000, 2'd0, 32'h0, 1'b1);
    pd_q.delete();
    run_txn(7'h17, 1'b1, 32'h00220000, 2'd0, 32'h0, 1'b1);
    run_txn(7'h7F, 1'b0, '0, 2'd0, 32'h0, 1'b1);
    run_txn(7'h03, 1'b1, 32'h1234, 2'd0, 32'h0, 1'b1);
    run_txn(7'h18, 1'b0, '0, 2'd0, 32'h0, 1'b1);
    run_txn(7'h17, 1'b0, '0, 2'd0, 32'h00001F00, 1'b1);
    run_txn(7'h16, 1'b1, 32'h5A5A5A5A, 2'd0, 32'hFFFFFFFF, 1'b1);
    run_txn(7'h10, 1'b0, '0, 2'd1, 32'h11111111, 1'b1);
    zero_wait = 1'b0;

    // Request held unready for five cycles
    force_req_delay = 5;
    run_txn(7'h10, 1'b1, 32'hA5C3_0F96, 2'd0, 32'h0, 1'b1);
    force_req_delay = -1;

    // Reset while polling: leave a nonzero completion behind first
    run_txn(7'h05, 1'b0, '0, 2'd0, 32'hCAFEF00D, 1'b1);
    pd_q.delete(); pr_q.delete();
    poll_hs = 0;
    run_txn(7'h17, 1'b1, 32'h00220000, 2'd0, 32'h0, 1'b0);
    g = 0;
    while (!(poll_hs >= 2 && bus.dmi_resp_ready_o === 1'b1) && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("poll_resp_reached", 32'(g >= 500), 0);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("midrst_done_valid", 32'(bus.done_valid_o), 0);
      check("midrst_host_ready", 32'(bus.host_ready_o), 0);
      check("midrst_dmi_req_valid", 32'(bus.dmi_req_valid_o), 0);
      check("midrst_dmi_resp_ready", 32'(bus.dmi_resp_ready_o), 0);
      check("midrst_done_rdata", bus.done_rdata_o, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_host_ready", 32'(bus.host_ready_o), 1);
    check("release_done_valid", 32'(bus.done_valid_o), 0);
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      k = int'($urandom_range(0, 9));
      if (k < 2)      addr = 7'($urandom_range(0, 127));
      else if (k < 5) addr = 7'h17;
      else            addr = 7'($urandom_range(4, 23));
      wr = (addr == 7'h17) ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
      zero_wait = ($urandom_range(0, 3) == 0);
      mresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      pd_q.delete(); pr_q.delete();
      k = int'($urandom_range(0, POLL_LIMIT + 1));
      for (int i = 0; i < k; i++) pd_q.push_back($urandom | (32'h1 << BUSY_BIT));
      pd_q.push_back($urandom & ~(32'h1 << BUSY_BIT));
      for (int i = 0; i <= k; i++)
        pr_q.push_back(($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
      run_txn(addr, wr, $urandom, mresp, $urandom, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    zero_wait = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_csr_initiator.md
DM_CSR_INITIATOR -- requirements
Module: dm_csr_initiator

Interface
REQ-001 Parameter POLL_LIMIT, default 16: maximum AbstractCS reads after a Command write before timeout.
REQ-002 Parameter BUSY_BIT, default 12: AbstractCS busy bit position.
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_ni  input  1  synchronous, active-low reset.
REQ-005 host_valid_i  input  1  host request valid.
REQ-006 host_ready_o  output  1  block accepts host request.
REQ-007 host_write_i  input  1  1=write, 0=read.
REQ-008 host_addr_i  input  7  DM CSR address.
REQ-009 host_wdata_i  input  32  write data.
REQ-010 done_valid_o  output  1  one-cycle completion pulse.
REQ-011 done_rdata_o  output  32  read data, or final AbstractCS value for Command writes.
REQ-012 done_err_o  output  1  error flag, qualified by done_valid_o.
REQ-013 dmi_req_valid_o  output  1  DMI request valid.
REQ-014 dmi_req_ready_i  input  1  DMI request accepted.
REQ-015 dmi_req_addr_o  output  7  DMI address.
REQ-016 dmi_req_op_o  output  2  0=nop, 1=read, 2=write.
REQ-017 dmi_req_data_o  output  32  DMI write data.
REQ-018 dmi_resp_valid_i  input  1  DMI response valid.
REQ-019 dmi_resp_ready_o  output  1  ready for response.
REQ-020 dmi_resp_data_i  input  32  response data.
REQ-021 dmi_resp_resp_i  input  2  0=success, nonzero=error.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, RESP, POLL_REQ, POLL_RESP, DONE.
REQ-023 host_ready_o SHALL be 1 only in IDLE; a request transfers when host_valid_i and host_ready_o are both 1, and its fields are captured into registers.
REQ-024 Legal addresses SHALL be 0x04..0x17 inclusive; an illegal address SHALL go IDLE->DONE without any DMI transaction and set done_err_o=1, done_rdata_o=0.
REQ-025 Legal address: IDLE->REQ; REQ holds dmi_req_valid_o=1 with op=2 (write) or 1 (read), captured addr/data; addr/op/data stable until dmi_req_ready_i; on handshake ->RESP.
REQ-026 dmi_resp_ready_o SHALL be 1 only in RESP and POLL_RESP; outside those states dmi_req_op_o=0 and dmi_req_valid_o=0.
REQ-027 RESP on handshake: nonzero resp -> DONE with done_err_o=1; success read -> DONE with done_rdata_o=dmi_resp_data_i; success write to non-Command address -> DONE with done_rdata_o=0; success write to Command (0x17) -> POLL_REQ with poll counter cleared.
REQ-028 POLL_REQ SHALL issue read of AbstractCS (0x16) with the REQ handshake rules, then ->POLL_RESP.
REQ-029 POLL_RESP on handshake: counter increments (saturating at POLL_LIMIT); nonzero resp -> DONE err=1; busy bit=0 -> DONE with done_rdata_o=response, done_err_o=1 iff bits[10:8] nonzero (cmderr); busy=1 and counter+1<POLL_LIMIT -> POLL_REQ; busy=1 and counter+1=POLL_LIMIT -> DONE err=1, rdata=response.
REQ-030 DONE SHALL last exactly one cycle with done_valid_o=1, then ->IDLE; done_rdata_o/done_err_o hold their value until the next DONE.
REQ-031 Latency: zero-wait read/write SHALL complete with done_valid_o 3 cycles after the accept edge (REQ, RESP, DONE); a response arriving in the same cycle as the request handshake is ignored.
REQ-032 Poll counter width SHALL be clog2(POLL_LIMIT+1) bits.

Reset
REQ-033 rst_ni=0 at a rising edge SHALL force IDLE, poll counter 0, all outputs 0 except host_ready_o, which becomes 1 the first cycle after reset release; reset mid-transaction abandons it with no done pulse.

Verification
REQ-034 Read 0x04, DMI ready/response immediate with data 0xDEADBEEF -> done_valid_o 3 cycles after accept, rdata=0xDEADBEEF, err=0.
REQ-035 Write 0x17 data 0x00220000, AbstractCS reads return 0x1000 twice then 0x0000 -> 3 reads of 0x16 observed, done rdata=0, err=0.
REQ-036 Write 0x17, AbstractCS returns 0x0300 (busy=0, cmderr=3) -> done err=1, rdata=0x0300.
REQ-037 Write 0x17, AbstractCS always 0x1000, POLL_LIMIT=16 -> exactly 16 poll reads, done err=1, rdata=0x1000.
REQ-038 Read 0x7F -> no dmi_req_valid_o, done err=1 one cycle after accept; separately, dmi_req_ready_i held 0 for 5 cycles -> addr/op/data stable throughout.
REQ-039 rst_ni=0 during POLL_RESP -> no done pulse, IDLE, host_ready_o=1 the cycle after release.
